// File: rtl/ngc_fifo_arbiter.sv
// ngc_fifo_arbiter: round-robin, packet-locking arbiter that feeds words from
// NUM_REQ requesters into a downstream ngc_fifo. An owner keeps the grant for
// the length of its packet. The FIFO push and data are registered, so the
// room check counts the push that is still in flight.
module ngc_fifo_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic [$clog2(SIZE):0]         fifo_num,
  input  logic                          fifo_full
);

  localparam int CW = $clog2(SIZE) + 1;   // fifo_num width
  localparam int RW = CW + 1;             // room arithmetic width, cannot wrap
  localparam int PW = $clog2(NUM_REQ);    // requester index width

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [NUM_REQ-1:0]      grant_nxt_s;
  logic [PW-1:0]           rr_ptr_r;
  logic [PW-1:0]           rr_ptr_nxt_s;
  logic [PW-1:0]           owner_r;
  logic [PW-1:0]           owner_nxt_s;
  logic                    take_s;
  logic [PW-1:0]           sel_s;
  logic                    found_s;
  logic [PW-1:0]           win_s;
  logic [RW-1:0]           level_s;
  logic                    room_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;

  // First requesting index at or above ptr, wrapping; MSB of result = found.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                          input logic [PW-1:0]      ptr);
    logic          found;
    logic [PW-1:0] idx;
    logic [PW:0]   cand;
    found = 1'b0;
    idx   = {PW{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!found && r[cand[PW-1:0]]) begin
        found = 1'b1;
        idx   = cand[PW-1:0];
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // Index + 1 modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] v);
    if (v == PW'(NUM_REQ - 1)) begin
      return {PW{1'b0}};
    end else begin
      return v + PW'(1);
    end
  endfunction

  // One-hot vector with bit v set.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] v);
    logic [NUM_REQ-1:0] oh;
    oh    = {NUM_REQ{1'b0}};
    oh[v] = 1'b1;
    return oh;
  endfunction

  assign {found_s, win_s} = rr_pick(req, rr_ptr_r);
  assign level_s          = RW'(fifo_num) + RW'(fifo_push);
  assign room_s           = (level_s < RW'(SIZE)) && !fifo_full;
  assign sel_data_s       = req_data[int'(sel_s)*DATA_WIDTH +: DATA_WIDTH];

  // State register: arbitration state, grant, round-robin pointer, owner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      grant    <= {NUM_REQ{1'b0}};
      rr_ptr_r <= {PW{1'b0}};
      owner_r  <= {PW{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      grant    <= grant_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      owner_r  <= owner_nxt_s;
    end
  end

  // Next-state logic: pick a word to accept and decide lock / release.
  always_comb begin
    state_nxt_s  = state_r;
    grant_nxt_s  = grant;
    rr_ptr_nxt_s = rr_ptr_r;
    owner_nxt_s  = owner_r;
    take_s       = 1'b0;
    sel_s        = {PW{1'b0}};
    case (state_r)
      IDLE: begin
        if (room_s && found_s) begin
          take_s = 1'b1;
          sel_s  = win_s;
          if (req_last[win_s]) begin
            rr_ptr_nxt_s = next_idx(win_s);
          end else begin
            state_nxt_s = LOCK;
            grant_nxt_s = onehot(win_s);
            owner_nxt_s = win_s;
          end
        end else begin
          take_s = 1'b0;
        end
      end
      LOCK: begin
        // Only the owner may move; a silent owner simply holds the lock.
        if (room_s && req[owner_r]) begin
          take_s = 1'b1;
          sel_s  = owner_r;
          if (req_last[owner_r]) begin
            state_nxt_s  = IDLE;
            grant_nxt_s  = {NUM_REQ{1'b0}};
            rr_ptr_nxt_s = next_idx(owner_r);
          end else begin
            state_nxt_s = LOCK;
          end
        end else begin
          take_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // Output logic: combinational one-hot ack, held low during reset.
  always_comb begin
    ack = {NUM_REQ{1'b0}};
    if (rst && take_s) begin
      ack = onehot(sel_s);
    end else begin
      ack = {NUM_REQ{1'b0}};
    end
  end

  // FIFO write port: the accepted word is pushed on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo_push <= 1'b0;
      fifo_din  <= {DATA_WIDTH{1'b0}};
    end else if (take_s) begin
      fifo_push <= 1'b1;
      fifo_din  <= sel_data_s;
    end else begin
      fifo_push <= 1'b0;
    end
  end

endmodule
